dmem_ctrl: RTL

//  Initiator side of the data-memory port. Turns CPU load/store requests into

---
 rtl/dmem_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory initiator: CPU load/store bursts of 1..4 bytes onto a
// registered-read data memory, with address auto-increment.
module dmem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              reset_ctrl_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] read_val,
  output logic              REDMEM,
  input  logic [DATA_W-1:0] data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_DATA
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          beats_d = req_len;
          state_d = req_write ? S_WR : S_RD_ADDR;
        end
      end
      S_WR: begin
        if (wdata_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          if (beats_q == '0) state_d = S_IDLE;
          else beats_d = beats_q - LEN_W'(1);
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: begin
        // memory re-reads addr_q every cycle, so a stall keeps data stable
        if (rsp_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          if (beats_q == '0) begin
            state_d = S_IDLE;
          end else begin
            beats_d = beats_q - LEN_W'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ctrl_n) begin
    if (!reset_ctrl_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign wdata_ready = (state_q == S_WR);
  assign rsp_valid   = (state_q == S_RD_DATA);
  assign rsp_data    = data;
  assign dmem_addr   = addr_q;
  assign REDMEM      = wdata_ready & wdata_valid;
  assign read_val    = wdata_ready ? wdata : '0;

endmodule
